// File: rtl/result_display_if.sv
// Result bus between the arithmetic unit and the display stage.
// The arithmetic side drives start/op/result and watches busy/done.
interface result_display_if;
  logic       start;
  logic [1:0] op;
  logic [8:0] result;
  logic       busy;
  logic       done;

  modport master (
    output start,
    output op,
    output result,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  op,
    input  result,
    output busy,
    output done
  );
endinterface

// File: rtl/result_display.sv
// Captures an arithmetic result and shows it on four 7-segment digits.
// Binary to BCD runs as a sequential double-dabble, one bit per clock.
module result_display #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  result_display_if.slave bus,
  output logic [7:0] hex3,
  output logic [7:0] hex2,
  output logic [7:0] hex1,
  output logic [7:0] hex0
);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    UPDATE
  } state_t;

  localparam logic [7:0] BLANK =
    ACTIVE_LOW ? 8'hFF : 8'h00;

  state_t      state_q, state_d;
  logic [7:0]  mag_q, mag_d;
  logic [11:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic [7:0]  hex3_q, hex3_d;
  logic [7:0]  hex2_q, hex2_d;
  logic [7:0]  hex1_q, hex1_d;
  logic [7:0]  hex0_q, hex0_d;
  logic [11:0] adj;
  logic [19:0] sh;

  function automatic logic [7:0] seg(
    input logic [3:0] d
  );
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] pol(
    input logic [7:0] raw
  );
    return ACTIVE_LOW ? raw : ~raw;
  endfunction

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    err_d   = err_q;
    done_d  = 1'b0;
    hex3_d  = hex3_q;
    hex2_d  = hex2_q;
    hex1_d  = hex1_q;
    hex0_d  = hex0_q;
    adj     = bcd_q;
    sh      = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          neg_d   = 1'b0;
          err_d   = 1'b0;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONV;
          unique case (bus.op)
            2'b00: mag_d = {3'b0, bus.result[8],
                            bus.result[3:0]};
            2'b01: begin
              mag_d = {4'd0, bus.result[3:0]};
              if (bus.result[8]) begin
                mag_d = 8'd16 - {4'd0, bus.result[3:0]};
                neg_d = 1'b1;
              end
            end
            2'b10: mag_d = bus.result[7:0];
            2'b11: begin
              mag_d = bus.result[7:0];
              err_d = bus.result[8];
            end
          endcase
        end
      end
      CONV: begin
        for (int i = 0; i < 3; i++) begin
          if (bcd_q[i*4 +: 4] >= 4'd5)
            adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
        sh    = {adj, mag_q} << 1;
        bcd_d = sh[19:8];
        mag_d = sh[7:0];
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd7)
          state_d = UPDATE;
      end
      UPDATE: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (err_q) begin
          hex3_d = pol(8'hFF);
          hex2_d = pol(8'h86);
          hex1_d = pol(8'hAF);
          hex0_d = pol(8'hAF);
        end else begin
          hex3_d = pol(neg_q ? 8'hBF : 8'hFF);
          hex2_d = pol((bcd_q[11:8] == 4'd0) ?
                       8'hFF : seg(bcd_q[11:8]));
          // tens only blank when it is a leading zero
          hex1_d = pol((bcd_q[11:4] == 8'd0) ?
                       8'hFF : seg(bcd_q[7:4]));
          hex0_d = pol(seg(bcd_q[3:0]));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      hex3_q  <= BLANK;
      hex2_q  <= BLANK;
      hex1_q  <= BLANK;
      hex0_q  <= BLANK;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
      done_q  <= done_d;
      hex3_q  <= hex3_d;
      hex2_q  <= hex2_d;
      hex1_q  <= hex1_d;
      hex0_q  <= hex0_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign hex3     = hex3_q;
  assign hex2     = hex2_q;
  assign hex1     = hex1_q;
  assign hex0     = hex0_q;

endmodule

// File: tb/tb_result_display.sv
// Randomized bench for result_display against a decimal display model.
// Directed cases cover reset, sign, blanking, error and held start.
module tb_result_display;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] hex3, hex2, hex1, hex0;
  int checks = 0;
  int errors = 0;

  result_display_if bus ();

  result_display #(.ACTIVE_LOW(1'b1)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .hex3 (hex3),
    .hex2 (hex2),
    .hex1 (hex1),
    .hex0 (hex0)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [7:0] digit(input int d);
    logic [7:0] t [10];
    t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return t[d];
  endfunction

  function automatic logic [31:0] model(
    input logic [1:0] op,
    input logic [8:0] res
  );
    int  v;
    int  h, t, o;
    bit  neg;
    logic [7:0] s3, s2, s1, s0;
    neg = 0;
    case (op)
      2'b00: v = int'(res[8]) * 16 + int'(res[3:0]);
      2'b01: begin
        if (res[8]) begin
          v   = 16 - int'(res[3:0]);
          neg = 1;
        end else begin
          v = int'(res[3:0]);
        end
      end
      2'b10: v = int'(res[7:0]);
      default: begin
        if (res[8]) return {8'hFF, 8'h86, 8'hAF, 8'hAF};
        v = int'(res[7:0]);
      end
    endcase
    h  = v / 100;
    t  = (v / 10) % 10;
    o  = v % 10;
    s3 = neg ? 8'hBF : 8'hFF;
    s2 = (h == 0) ? 8'hFF : digit(h);
    s1 = (h == 0 && t == 0) ? 8'hFF : digit(t);
    s0 = digit(o);
    return {s3, s2, s1, s0};
  endfunction

  function automatic logic [31:0] hexes();
    return {hex3, hex2, hex1, hex0};
  endfunction

  task automatic run(
    input string      tag,
    input logic [1:0] op,
    input logic [8:0] res
  );
    int busy_n;
    int lat;
    logic [31:0] exp;
    exp = model(op, res);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.result = res;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.op     = 2'($urandom);
    bus.result = 9'($urandom);
    busy_n = 0;
    lat    = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = i;
        break;
      end
      if (bus.busy) busy_n++;
    end
    check({tag, " latency"}, lat, 10);
    check({tag, " busy"}, busy_n, 9);
    check({tag, " hex"}, hexes(), exp);
    @(negedge clk);
    check({tag, " done pulse"}, {31'd0, bus.done}, 0);
  endtask

  initial begin
    int dn;
    logic [31:0] held;
    bus.start  = 1'b0;
    bus.op     = 2'b00;
    bus.result = '0;

    // T1
    #12;
    check("rst hex", hexes(), 32'hFFFFFFFF);
    check("rst busy", {31'd0, bus.busy}, 0);
    check("rst done", {31'd0, bus.done}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle hex", hexes(), 32'hFFFFFFFF);
    check("idle flags", {30'd0, bus.busy, bus.done}, 0);

    // T2-T5
    run("add31", 2'b00, 9'h10F);
    check("add31 abs", hexes(), 32'hFFFFB0F9);
    run("sub-3", 2'b01, 9'h10D);
    check("sub-3 abs", hexes(), 32'hBFFFFFB0);
    run("sub5", 2'b01, 9'h005);
    run("sub-16", 2'b01, 9'h100);
    run("mul225", 2'b10, 9'h0E1);
    check("mul225 abs", hexes(), 32'hFFA4A492);
    run("mul255", 2'b10, 9'h0FF);
    run("mul0", 2'b10, 9'h000);
    check("mul0 abs", hexes(), 32'hFFFFFFC0);
    run("mul105", 2'b10, 9'h069);
    run("diverr", 2'b11, 9'h100);
    check("diverr abs", hexes(), 32'hFF86AFAF);
    run("div10", 2'b11, 9'h00A);
    check("div10 abs", hexes(), 32'hFFFFF9C0);

    // T6
    held = model(2'b10, 9'h0E1);
    dn = 0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = 2'b10;
    bus.result = 9'h0E1;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) bus.result = 9'h0FF;
      @(negedge clk);
      if (bus.done) begin
        dn++;
        if (dn == 1)
          check("held first", hexes(), held);
        if (dn == 2)
          check("held second", hexes(),
                model(2'b10, 9'h0FF));
      end
    end
    rst = 1'b1;
    bus.start = 1'b0;
    #1;
    check("midrst hex", hexes(), 32'hFFFFFFFF);
    check("midrst busy", {31'd0, bus.busy}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    check("held dones", dn, 2);
    check("post rst hex", hexes(), 32'hFFFFFFFF);
    run("after rst", 2'b00, 9'h007);

    for (int n = 0; n < 40; n++) begin
      run("rand", 2'($urandom), 9'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
